us_tick_scheduler: RTL and testbench
====================================

# us_tick_scheduler

Controller and scheduler for the 1 µs interval timer peripheral. On request it programs the timer's period through the timer's 16-bit register slave port, then consumes the timer's `timeout_pulse` tick. It shares that single tick among `N_CH` independent one-shot delay channels, each with a programmable delay in ticks. It sits between the timer and the FEE timing logic, replacing per-client software timers.

## Interface
- `N_CH`, 4: number of delay channels (1–16).
- `CNT_W`, 16: delay counter width in ticks.
- `clk` in 1: system clock; same clock as the timer.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse; (re)programs the timer with `cfg_period`.
- `cfg_period` in 32: timer load value (tick period = value+1 clocks); sampled in the `cfg_start` cycle.
- `cfg_done` out 1: high while in RUN (timer programmed, ticks counted).
- `tmr_address` out 3: timer register address.
- `tmr_chipselect` out 1: timer slave select.
- `tmr_write_n` out 1: timer write strobe, active-low.
- `tmr_writedata` out 16: timer write data.
- `tmr_timeout_pulse` in 1: one-cycle tick from the timer.
- `ch_arm` in N_CH: per-channel arm pulse.
- `ch_delay` in N_CH*CNT_W: per-channel delay, channel i at bits [i*CNT_W +: CNT_W]; sampled on arm.
- `ch_cancel` in N_CH: per-channel cancel pulse.
- `ch_busy` out N_CH: channel armed and counting.
- `ch_expire` out N_CH: one-cycle expiry pulse.

## Operation
- Timer register map: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3. The timer slave has no waitrequest; each write completes in its own cycle.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTL, WR_ST, RUN.
- Reset lands in IDLE. In IDLE and RUN, `cfg_start` latches `cfg_period` and moves to WR_PL.
- WR_PL writes addr 2 with period[15:0]. WR_PH writes addr 3 with period[31:16]. WR_CTL writes addr 1 with data 0 (timer IRQ disabled; this block owns the tick). WR_ST writes addr 0 with data 0 to clear the timeout flag. Then → RUN. Each state lasts exactly 1 cycle.
- `cfg_start` during WR_* states is ignored.
- Ticks are counted only in RUN. Ticks arriving in IDLE or WR_* are dropped, and channel counters hold.
- Channel arm with D≥1: counter←D, busy←1. Each counted tick decrements the counter. The tick that takes the counter from 1→0 clears busy and schedules expire.
- Arm with D=0: no busy; expire pulses the cycle after arm, independent of FSM state.
- Arm while busy: restart with the new D; no expire for the old arm.
- Cancel: busy←0, counter←0, no expire. A pending expire already registered still fires.
- Arm and cancel in the same cycle: arm wins.
- Arm in the same cycle as a tick: the tick is not applied to the new count.
- Channels are fully independent. Several expires may pulse in the same cycle.

## Timing
- Reset values:
  - all outputs 0, except `tmr_write_n`=1;
  - `tmr_chipselect`=0, `tmr_address`=0, `tmr_writedata`=0;
  - `cfg_done`=0, `ch_busy`=0, `ch_expire`=0.
- All outputs are registered.
- `cfg_start` at cycle T:
  - writes are presented at T+1 (addr 2), T+2 (addr 3), T+3 (addr 1), T+4 (addr 0);
  - `tmr_chipselect`=1 and `tmr_write_n`=0 only during those cycles;
  - `cfg_done` rises at T+5.
- Reprogram from RUN: `cfg_done` falls at T+1.
- `ch_busy` rises the cycle after arm.
- `ch_expire` pulses the cycle after the final counted tick, and `ch_busy` falls in the same cycle.
- Delay D therefore expires on the D-th counted tick strictly after the arm cycle.
- Reset mid-sequence: abort immediately to IDLE with all channels cleared. No partial write is retried.

## Structure
- Package `us_tick_sched_pkg`: FSM state enum, timer register address constants (STATUS/CONTROL/PERIODL/PERIODH), and the default period 49 (1 µs at 50 MHz).
- Sub-module `us_tick_sched_channel`: one countdown channel (arm/cancel/tick/busy/expire), generated N_CH times.
- The top level holds the FSM and the timer write master.

## Test plan
- Reset, then `cfg_start` with period 0x0001_0031 → writes (2,0x0031), (3,0x0001), (1,0x0000), (0,0x0000) on consecutive cycles; `cfg_done` high 5 cycles after start.
- In RUN, arm ch0 D=3 with ticks every 50 clocks → `ch_expire[0]` one cycle after the 3rd tick; `ch_busy[0]` high from arm+1 until then.
- Arm ch1 D=0 → `ch_expire[1]` next cycle, `ch_busy[1]` never set. Arm ch2 D=5 and cancel after 2 ticks → no expire.
- Arm ch3 D=2 coincident with a tick → expires after 2 further ticks. Re-arm ch0 D=4 while busy with 1 remaining → expire only after 4 more ticks.
- `cfg_start` in RUN with ch0 busy at count 2 → ticks during reprogram ignored; ch0 expires after 2 ticks once `cfg_done` returns.
- Assert `reset` during WR_PH → outputs return to reset values next cycle; FSM in IDLE; all channels idle.

Source files
------------

// File: rtl/us_tick_sched_pkg.sv
// Shared types and constants for the 1 us tick scheduler.
package us_tick_sched_pkg;

    // Controller FSM: one state per timer register write, then RUN.
    typedef enum logic [2:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StWrSt,
        StRun
    } sched_state_e;

    // Timer register map.
    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrPeriodL = 3'd2;
    localparam logic [2:0] AddrPeriodH = 3'd3;

    // 1 us tick at 50 MHz (load value, period = value + 1 clocks).
    localparam logic [31:0] DefaultPeriod = 32'd49;

endpackage

// File: rtl/us_tick_scheduler_if.sv
// Register-slave bus of the interval timer plus its tick output.
interface us_tick_scheduler_if;

    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_timeout_pulse;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_timeout_pulse
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_timeout_pulse
    );

endinterface

// File: rtl/us_tick_sched_channel.sv
// One one-shot countdown channel driven by the shared, already-qualified tick.
module us_tick_sched_channel #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic [CNT_W-1:0] delay,
    input  logic             cancel,
    input  logic             tick,
    output logic             busy,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Arm beats cancel beats tick; a tick in the arm cycle is not applied to the new count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            busy   <= 1'b0;
            expire <= 1'b0;
        end else if (arm) begin
            count  <= delay;
            busy   <= (delay != '0);
            expire <= (delay == '0);
        end else if (cancel) begin
            count  <= '0;
            busy   <= 1'b0;
            expire <= 1'b0;
        end else if (busy && tick) begin
            count  <= count - 1'b1;
            busy   <= (count != CNT_W'(1));
            expire <= (count == CNT_W'(1));
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/us_tick_scheduler.sv
// Programs the interval timer and shares its tick among N_CH one-shot delay channels.
module us_tick_scheduler
    import us_tick_sched_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [31:0]            cfg_period,
    output logic                   cfg_done,
    us_tick_scheduler_if.master    tmr,
    input  logic [N_CH-1:0]        ch_arm,
    input  logic [N_CH*CNT_W-1:0]  ch_delay,
    input  logic [N_CH-1:0]        ch_cancel,
    output logic [N_CH-1:0]        ch_busy,
    output logic [N_CH-1:0]        ch_expire
);

    sched_state_e state;
    logic [15:0]  period_hi;
    logic         tick_run;

    // Controller FSM and timer write master; bus outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= StIdle;
            period_hi          <= DefaultPeriod[31:16];
            cfg_done           <= 1'b0;
            tmr.tmr_address    <= '0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_writedata  <= '0;
        end else begin
            tmr.tmr_address    <= '0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_writedata  <= '0;
            case (state)
                StIdle, StRun: begin
                    if (cfg_start) begin
                        // Low half goes out straight away, only the high half needs holding.
                        period_hi          <= cfg_period[31:16];
                        state              <= StWrPl;
                        cfg_done           <= 1'b0;
                        tmr.tmr_address    <= AddrPeriodL;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_writedata  <= cfg_period[15:0];
                    end
                end
                StWrPl: begin
                    state              <= StWrPh;
                    tmr.tmr_address    <= AddrPeriodH;
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_writedata  <= period_hi;
                end
                StWrPh: begin
                    // IRQ stays disabled: the tick is consumed here, not by software.
                    state              <= StWrCtl;
                    tmr.tmr_address    <= AddrControl;
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                end
                StWrCtl: begin
                    state              <= StWrSt;
                    tmr.tmr_address    <= AddrStatus;
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                end
                StWrSt: begin
                    state    <= StRun;
                    cfg_done <= 1'b1;
                end
                default: begin
                    state    <= StIdle;
                    cfg_done <= 1'b0;
                end
            endcase
        end
    end

    // Ticks outside RUN are dropped so channel counters hold during (re)programming.
    assign tick_run = tmr.tmr_timeout_pulse && (state == StRun);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        us_tick_sched_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .arm    (ch_arm[i]),
            .delay  (ch_delay[i*CNT_W +: CNT_W]),
            .cancel (ch_cancel[i]),
            .tick   (tick_run),
            .busy   (ch_busy[i]),
            .expire (ch_expire[i])
        );
    end

endmodule

// File: tb/tb_us_tick_scheduler.sv
// Scoreboard bench for us_tick_scheduler: the bench plays the timer and models the scheduler.
module tb_us_tick_scheduler;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cfg_start;
    logic [31:0]           cfg_period;
    logic                  cfg_done;
    logic [N_CH-1:0]       ch_arm;
    logic [N_CH*CNT_W-1:0] ch_delay;
    logic [N_CH-1:0]       ch_cancel;
    logic [N_CH-1:0]       ch_busy;
    logic [N_CH-1:0]       ch_expire;

    us_tick_scheduler_if tmr ();

    us_tick_scheduler #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_period (cfg_period),
        .cfg_done   (cfg_done),
        .tmr        (tmr),
        .ch_arm     (ch_arm),
        .ch_delay   (ch_delay),
        .ch_cancel  (ch_cancel),
        .ch_busy    (ch_busy),
        .ch_expire  (ch_expire)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;
    typedef struct {
        int              cyc;
        logic            done;
        logic [N_CH-1:0] busy;
    } st_t;
    typedef struct {
        int cyc;
        int ch;
    } ex_t;

    wr_t wr_q[$];
    st_t st_q[$];
    ex_t ex_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;

    // Reference model: configured timer, first RUN cycle, ticks left per channel.
    bit configured = 0;
    int run_from   = 0;
    int rem[N_CH];

    // Per-cycle requests from the scenario code.
    logic [N_CH-1:0]  arm_r    = '0;
    logic [N_CH-1:0]  cancel_r = '0;
    logic [CNT_W-1:0] dly_r[N_CH];
    bit               start_r  = 0;
    bit               rst_r    = 0;
    logic [31:0]      period_r = '0;
    int               tick_per = 50;
    int               tick_ctr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_state(input int c);
        st_t s;
        s.cyc  = c;
        s.done = configured && (c >= run_from);
        for (int i = 0; i < N_CH; i++) s.busy[i] = (rem[i] > 0);
        st_q.push_back(s);
    endtask

    task automatic push_wr(input int c, input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic push_ex(input int c, input int ch);
        ex_t e;
        e.cyc = c;
        e.ch  = ch;
        ex_q.push_back(e);
    endtask

    task automatic model_step(input int c, input bit tick);
        bit run_c;
        bit counted;
        run_c = configured && (c >= run_from);
        if (start_r && !(configured && c < run_from)) begin
            push_wr(c + 1, 3'd2, period_r[15:0]);
            push_wr(c + 2, 3'd3, period_r[31:16]);
            push_wr(c + 3, 3'd1, 16'h0000);
            push_wr(c + 4, 3'd0, 16'h0000);
            run_from   = c + 5;
            configured = 1;
        end
        counted = tick && run_c;
        for (int i = 0; i < N_CH; i++) begin
            if (arm_r[i]) begin
                rem[i] = int'(dly_r[i]);
                if (dly_r[i] == '0) push_ex(c + 1, i);
            end else if (cancel_r[i]) begin
                rem[i] = 0;
            end else if (rem[i] > 0 && counted) begin
                rem[i]--;
                if (rem[i] == 0) push_ex(c + 1, i);
            end
        end
        push_state(c + 1);
    endtask

    task automatic model_reset(input int c);
        configured = 0;
        for (int i = 0; i < N_CH; i++) rem[i] = 0;
        while (wr_q.size() > 0 && wr_q[$].cyc >= c) void'(wr_q.pop_back());
        while (ex_q.size() > 0 && ex_q[$].cyc >= c) void'(ex_q.pop_back());
        if (st_q.size() > 0 && st_q[$].cyc == c) void'(st_q.pop_back());
        push_state(c);
        push_state(c + 1);
    endtask

    // One clock: drive requests just after the edge, then advance the model.
    task automatic cycle();
        int c;
        bit tick;
        @(posedge clk);
        #1;
        c        = cyc;
        tick     = (tick_ctr == tick_per - 1);
        tick_ctr = tick ? 0 : tick_ctr + 1;
        reset                 = rst_r;
        cfg_start             = start_r;
        cfg_period            = period_r;
        tmr.tmr_timeout_pulse = tick;
        ch_arm                = arm_r;
        ch_cancel             = cancel_r;
        for (int i = 0; i < N_CH; i++) ch_delay[i*CNT_W +: CNT_W] = dly_r[i];
        if (rst_r) model_reset(c);
        else model_step(c, tick);
        arm_r    = '0;
        cancel_r = '0;
        start_r  = 0;
        rst_r    = 0;
        mon_en   = 1;
    endtask

    task automatic until_tick();
        while (tick_ctr != tick_per - 1) cycle();
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    logic [N_CH-1:0] exp_v;
    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                st_t s;
                s = st_q.pop_front();
                check("cfg_done", 64'(cfg_done), 64'(s.done));
                check("ch_busy", 64'(ch_busy), 64'(s.busy));
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                wr_t w;
                w = wr_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write due cycle %0d: got none expected addr %0d data %0h",
                         w.cyc, w.addr, w.data);
            end
            if (tmr.tmr_chipselect || !tmr.tmr_write_n) begin
                if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(tmr.tmr_address), 64'(w.addr));
                    check("wr_data", 64'(tmr.tmr_writedata), 64'(w.data));
                    check("wr_strobe", 64'({tmr.tmr_chipselect, tmr.tmr_write_n}), 64'(2'b10));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write at cycle %0d: got addr %0d data %0h expected none",
                             cyc, tmr.tmr_address, tmr.tmr_writedata);
                end
            end
            exp_v = '0;
            while (ex_q.size() > 0 && ex_q[0].cyc <= cyc) begin
                ex_t e;
                e = ex_q.pop_front();
                exp_v[e.ch] = 1'b1;
            end
            if (exp_v != '0 || ch_expire != '0) check("ch_expire", 64'(ch_expire), 64'(exp_v));
            if (reset) begin
                check("rst_outputs",
                      64'({tmr.tmr_address, tmr.tmr_chipselect, tmr.tmr_write_n,
                           tmr.tmr_writedata, cfg_done, ch_busy, ch_expire}),
                      64'({3'd0, 1'b0, 1'b1, 16'h0000, 1'b0, {N_CH{1'b0}}, {N_CH{1'b0}}}));
            end
        end
    end

    initial begin
        reset                 = 1'b1;
        cfg_start             = 1'b0;
        cfg_period            = '0;
        ch_arm                = '0;
        ch_cancel             = '0;
        ch_delay              = '0;
        tmr.tmr_timeout_pulse = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            dly_r[i] = '0;
            rem[i]   = 0;
        end

        repeat (3) begin
            rst_r = 1;
            cycle();
        end
        repeat (3) cycle();

        // D=0 expires even while the timer is unprogrammed.
        arm_r[1] = 1'b1; dly_r[1] = 0;
        cycle();
        repeat (2) cycle();

        // Program 0x0001_0031 and settle into RUN.
        start_r = 1; period_r = 32'h0001_0031;
        cycle();
        repeat (8) cycle();

        // ch0 D=3 across three 50-clock ticks.
        arm_r[0] = 1'b1; dly_r[0] = 3;
        cycle();
        repeat (160) cycle();

        // ch1 D=0 and ch2 D=5, ch2 cancelled after two ticks.
        arm_r[1] = 1'b1; dly_r[1] = 0;
        arm_r[2] = 1'b1; dly_r[2] = 5;
        cycle();
        until_tick(); cycle();
        until_tick(); cycle();
        cancel_r[2] = 1'b1;
        cycle();
        repeat (10) cycle();

        // ch3 D=2 armed in a tick cycle.
        until_tick();
        arm_r[3] = 1'b1; dly_r[3] = 2;
        cycle();
        repeat (120) cycle();

        // ch0 D=2, one tick later re-armed with D=4.
        arm_r[0] = 1'b1; dly_r[0] = 2;
        cycle();
        until_tick(); cycle();
        arm_r[0] = 1'b1; dly_r[0] = 4;
        cycle();
        repeat (220) cycle();

        // Reprogram from RUN with ch0 holding 2; a tick lands in WR_PH.
        arm_r[0] = 1'b1; dly_r[0] = 2;
        cycle();
        while (tick_ctr != tick_per - 3) cycle();
        start_r = 1; period_r = 32'h0000_0031;
        cycle();
        repeat (110) cycle();

        // Reset during WR_PH with ch1 busy.
        arm_r[1] = 1'b1; dly_r[1] = 7;
        cycle();
        start_r = 1; period_r = 32'h1234_5678;
        cycle();
        cycle();
        rst_r = 1;
        cycle();
        repeat (3) cycle();

        // Randomized traffic with fast ticks.
        tick_per = 5;
        tick_ctr = 0;
        start_r  = 1; period_r = $urandom;
        cycle();
        repeat (1500) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(11) == 0) begin
                    arm_r[i] = 1'b1;
                    dly_r[i] = CNT_W'($urandom_range(6));
                    if ($urandom_range(9) == 0) cancel_r[i] = 1'b1;
                end else if ($urandom_range(24) == 0) begin
                    cancel_r[i] = 1'b1;
                end
            end
            if ($urandom_range(149) == 0) begin
                start_r  = 1;
                period_r = $urandom;
            end
            if ($urandom_range(399) == 0) rst_r = 1;
            cycle();
        end
        repeat (20) cycle();
        @(posedge clk);
        mon_en = 0;

        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("ex_q_drained", 64'(ex_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
